// File: rtl/rvsteel_uart_pkg.sv
// Shared UART definitions: receiver state encoding and the baud divider calculation.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rvsteel_uart_pkg;

    // Receiver frame states. BREAK holds off decoding while the line stays low.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    // Clock cycles per bit. Uses integer division; the caller owns the rounding error.
    function automatic int cycles_per_baud(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/rvsteel_sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous inputs.
// Latency: 2 clock cycles.
// Backpressure: none; samples every cycle.
module rvsteel_sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rvsteel_uart_receiver.sv
// 8N1 UART receiver: synchronizes uart_rx, samples mid-bit, delivers bytes over valid/ready.
// Latency: rx_valid rises 2 + HALF_BAUD + 9*CYCLES_PER_BAUD + 1 cycles after the start edge.
// Backpressure: one holding register; a byte finishing while it is still full is dropped with an overrun pulse.
module rvsteel_uart_receiver
    import rvsteel_uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 12000000,
    parameter int UART_BAUD_RATE  = 9600
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_error,
    output logic       overrun
);

    localparam int CYCLES_PER_BAUD = cycles_per_baud(CLOCK_FREQUENCY, UART_BAUD_RATE);
    localparam int HALF_BAUD       = CYCLES_PER_BAUD / 2;
    localparam int CNT_W           = $clog2(CYCLES_PER_BAUD);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BAUD - 1);
    localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(CYCLES_PER_BAUD - 1);

    // Too few cycles per bit leaves no room for a meaningful mid-bit sample.
    if (CYCLES_PER_BAUD < 4) begin : g_cfg_check
        $error("rvsteel_uart_receiver: CYCLES_PER_BAUD must be at least 4");
    end

    uart_rx_state_t   state;
    uart_rx_state_t   state_next;
    logic             rx_sync;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_load;
    logic             sample;
    logic [2:0]       bit_idx;
    logic             bit_clr;
    logic             shift_en;
    logic [7:0]       shift_reg;
    logic             deliver;
    logic             frame_err_next;

    rvsteel_sync_2ff #(
        .RESET_VALUE(1'b1)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (uart_rx),
        .q     (rx_sync)
    );

    assign sample = (cnt == '0);

    // Frame state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle datapath controls.
    always_comb begin
        state_next     = state;
        cnt_load       = 1'b0;
        cnt_load_val   = BAUD_LOAD;
        shift_en       = 1'b0;
        bit_clr        = 1'b0;
        deliver        = 1'b0;
        frame_err_next = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_next   = START;
                    cnt_load     = 1'b1;
                    cnt_load_val = HALF_LOAD;
                end
            end
            START: begin
                if (sample) begin
                    if (rx_sync) begin
                        // Line went back high before mid-start: treat as noise.
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        cnt_load   = 1'b1;
                        bit_clr    = 1'b1;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_en = 1'b1;
                    cnt_load = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (sample) begin
                    if (rx_sync) begin
                        deliver    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_sync) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bit timer: reloads on demand, otherwise counts down and parks at zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt_load) begin
            cnt <= cnt_load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Bit index and LSB-first shift register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            if (bit_clr) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shift_reg <= {rx_sync, shift_reg[7:1]};
            end
        end
    end

    // Holding register, handshake and error pulses; all outputs are registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= frame_err_next;
            overrun     <= deliver && rx_valid && !rx_ready;
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rvsteel_uart_receiver.sv
// Scoreboard bench for rvsteel_uart_receiver: directed scenarios plus random frames.
// Latency: n/a.
// Backpressure: consumer ready is held low, held high or randomized per phase.
module tb_rvsteel_uart_receiver;

    localparam int CLK_HZ = 12000000;
    localparam int BAUD   = 600000;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int HALF   = CPB / 2;
    localparam int NOMINAL_LAT = 2 + HALF + 9 * CPB + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       frame_error;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    // 0: consumer stalled, 1: always ready, 2: random ready
    int ready_mode = 1;

    logic [7:0] exp_q[$];
    bit   model_full = 1'b0;
    int   fe_exp = 0;
    int   ov_exp = 0;
    int   fe_seen = 0;
    int   ov_seen = 0;

    bit         prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit         fe_prev = 1'b0;
    bit         ov_prev = 1'b0;

    rvsteel_uart_receiver #(
        .CLOCK_FREQUENCY (CLK_HZ),
        .UART_BAUD_RATE  (BAUD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model of one complete frame as seen by the consumer.
    function automatic void model_frame(input logic [7:0] b, input logic stop_level);
        if (!stop_level) begin
            fe_exp++;
        end else if (ready_mode == 0 && model_full) begin
            ov_exp++;
        end else begin
            exp_q.push_back(b);
            model_full = (ready_mode == 0);
        end
    endfunction

    // Hold the line at v for n cycles; entry and exit are 1 time unit after a rising edge.
    task automatic drive_bit(input logic v, input int n);
        uart_rx = v;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_level, input int stop_bits);
        model_frame(b, stop_level);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            drive_bit(b[i], CPB);
        end
        drive_bit(stop_level, CPB * stop_bits);
        uart_rx = 1'b1;
    endtask

    task automatic wait_valid_low(input string name);
        int n = 0;
        while (rx_valid && n < 4 * CPB) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(name, 32'(rx_valid), 32'(0));
    endtask

    // Consumer ready driver.
    always @(posedge clock) begin
        #1;
        case (ready_mode)
            0:       rx_ready = 1'b0;
            1:       rx_ready = 1'b1;
            default: rx_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: pops expected bytes on every handshake and tracks error pulses.
    always @(negedge clock) begin
        if (!reset) begin
            prev_hold = 1'b0;
            fe_prev   = 1'b0;
            ov_prev   = 1'b0;
        end else begin
            if (fe_prev) check("frame_error_width", 32'(frame_error), 32'(0));
            if (ov_prev) check("overrun_width", 32'(overrun), 32'(0));
            if (frame_error) fe_seen++;
            if (overrun) ov_seen++;
            if (prev_hold && rx_valid) check("rx_data_stable", 32'(rx_data), 32'(prev_data));
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h, expected none", rx_data);
                end else begin
                    check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
                end
            end
            prev_hold = rx_valid && !rx_ready;
            prev_data = rx_data;
            fe_prev   = frame_error;
            ov_prev   = overrun;
        end
    end

    initial begin
        int lat;
        logic [7:0] b;
        bit bad;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("reset_rx_data", 32'(rx_data), 32'(0));
        check("reset_rx_valid", 32'(rx_valid), 32'(0));
        check("reset_frame_error", 32'(frame_error), 32'(0));
        check("reset_overrun", 32'(overrun), 32'(0));
        reset = 1'b1;
        repeat (4) @(posedge clock);
        #1;

        // Single byte with latency measurement
        lat = 0;
        fork
            send_frame(8'h55, 1'b1, 1);
            begin
                while (!rx_valid && lat < 3 * NOMINAL_LAT) begin
                    @(posedge clock);
                    #1;
                    lat++;
                end
            end
        join
        checks++;
        if (lat < NOMINAL_LAT - 1 || lat > NOMINAL_LAT + 1) begin
            errors++;
            $display("FAIL latency: got %0d cycles, expected %0d +/- 1", lat, NOMINAL_LAT);
        end
        drive_bit(1'b1, CPB);

        // Back-to-back frames
        send_frame(8'hA5, 1'b1, 1);
        send_frame(8'h3C, 1'b1, 1);
        drive_bit(1'b1, CPB);

        // Glitch shorter than half a bit
        drive_bit(1'b0, HALF / 2);
        drive_bit(1'b1, 2 * CPB);
        check("glitch_no_valid", 32'(rx_valid), 32'(0));
        check("glitch_frame_error", 32'(fe_seen), 32'(fe_exp));
        send_frame(8'hC3, 1'b1, 1);
        drive_bit(1'b1, CPB);

        // Framing error with a long low line
        send_frame(8'hFF, 1'b0, 3);
        drive_bit(1'b1, CPB);
        check("frame_error_count", 32'(fe_seen), 32'(fe_exp));
        send_frame(8'h12, 1'b1, 1);
        drive_bit(1'b1, CPB);

        // Overrun while the consumer is stalled
        ready_mode = 0;
        drive_bit(1'b1, 2);
        send_frame(8'h11, 1'b1, 1);
        send_frame(8'h22, 1'b1, 1);
        drive_bit(1'b1, 4);
        check("overrun_count", 32'(ov_seen), 32'(ov_exp));
        check("overrun_rx_data", 32'(rx_data), 32'(8'h11));
        check("overrun_rx_valid", 32'(rx_valid), 32'(1));
        ready_mode = 1;
        model_full = 1'b0;
        wait_valid_low("overrun_drain");
        drive_bit(1'b1, CPB);

        // Reset during bit 4 of 0x99
        b = 8'h99;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) begin
            drive_bit(b[i], CPB);
        end
        drive_bit(b[4], HALF);
        reset = 1'b0;
        #1;
        check("midreset_rx_data", 32'(rx_data), 32'(0));
        check("midreset_rx_valid", 32'(rx_valid), 32'(0));
        check("midreset_frame_error", 32'(frame_error), 32'(0));
        check("midreset_overrun", 32'(overrun), 32'(0));
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        drive_bit(1'b1, 2 * CPB);
        send_frame(8'h7E, 1'b1, 1);
        drive_bit(1'b1, CPB);

        // Random frames, random consumer, occasional bad stop bit
        ready_mode = 2;
        for (int k = 0; k < 24; k++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            if (bad) begin
                send_frame(b, 1'b0, 1);
                drive_bit(1'b1, CPB);
            end else begin
                send_frame(b, 1'b1, 1);
                drive_bit(1'b1, $urandom_range(0, CPB) + 1);
            end
        end
        ready_mode = 1;
        drive_bit(1'b1, 2 * CPB);

        check("pending_bytes", 32'(exp_q.size()), 32'(0));
        check("final_frame_errors", 32'(fe_seen), 32'(fe_exp));
        check("final_overruns", 32'(ov_seen), 32'(ov_exp));
        check("final_rx_valid", 32'(rx_valid), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
